hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter STAGES, default 3, number of post-decode stages tracked (E, M, W for the default).
REQ-002 Parameter MUL_LAT, default 5, multiply busy cycles.
REQ-003 Parameter DIV_LAT, default 10, divide busy cycles.
REQ-004 Derived width SW = clog2(STAGES+1); CW = clog2(max(MUL_LAT,DIV_LAT)+1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 d_valid  input  1  decode-stage instruction present.
REQ-008 d_waddr  input  5  destination register of decode instruction.
REQ-009 d_tnew  input  2  cycles until result ready, counted from E entry.
REQ-010 d_rs, d_rt  input  5 each  source registers read by decode instruction.
REQ-011 d_tuse_rs, d_tuse_rt  input  2 each  cycles until rs/rt value is needed; 3 = not used.
REQ-012 d_md_start  input  1  decode instruction is mult/multu/div/divu.
REQ-013 d_md_div  input  1  with d_md_start: 1 = divide latency, 0 = multiply latency.
REQ-014 d_md_use  input  1  decode instruction is mfhi/mflo/mthi/mtlo.
REQ-015 stall  output  1  freeze F/D, bubble into E.
REQ-016 fwd_rs_sel, fwd_rt_sel  output  SW each  0 = register file, k+1 = forward from tracked stage k.
REQ-017 md_busy  output  1  multiply/divide unit occupied.

Function
REQ-018 Scoreboard SHALL hold STAGES entries {valid, waddr[4:0], tnew[1:0]}; entry 0 = E, entry STAGES-1 = last tracked stage.
REQ-019 Every cycle, entry k+1 SHALL load entry k with tnew = max(tnew_k-1, 0); the oldest entry is discarded.
REQ-020 Entry 0 SHALL load {d_valid && d_waddr!=0, d_waddr, d_tnew} when stall=0, else valid=0 (bubble).
REQ-021 Match for a source r (r!=0): valid entry with waddr==r; only the lowest-index (youngest) match SHALL be considered.
REQ-022 Source stall SHALL be 1 when youngest match exists and its tnew > that source's tuse; tuse=3 never stalls.
REQ-023 fwd_*_sel SHALL be k+1 when youngest match k has tnew==0, else 0; source $0 SHALL always give 0.
REQ-024 stall = d_valid && (rs stall || rt stall || md stall); combinational from state and decode inputs, no registered delay.
REQ-025 md counter: loads MUL_LAT or DIV_LAT when d_valid && d_md_start && stall=0; otherwise decrements while nonzero.
REQ-026 md_busy = (counter != 0); md stall = (d_md_use || d_md_start) && md_busy.
REQ-027 Issue of d_md_start on the cycle the counter reaches 1 SHALL stall; issue is accepted only when counter==0.
REQ-028 With d_valid=0, stall SHALL be 0, sels SHALL be 0 and a bubble SHALL enter entry 0.

Reset
REQ-029 reset=1 at clock edge SHALL clear all entry valid bits, waddr, tnew and the md counter to 0.
REQ-030 After reset: stall=0 (regardless of d_md_*), fwd_rs_sel=0, fwd_rt_sel=0, md_busy=0.
REQ-031 Reset mid-operation SHALL abandon in-flight writes and md countdown with no residual stall.

Configuration
REQ-032 Macro HAZARD_SCOREBOARD_MD_EN defined: md counter and md stall per REQ-025..027 present.
REQ-033 Macro undefined: no counter, md_busy tied 0, d_md_start/d_md_div/d_md_use ignored, md stall always 0.

Verification
REQ-034 Reset asserted 2 cycles, then idle -> stall=0, both sels=0, md_busy=0.
REQ-035 lw $2 (tnew=2), next add rs=$2 (tuse=1) -> stall=1 exactly 1 cycle; add then issues with fwd_rs_sel=0, and a later decode of $2 gets fwd_rs_sel=3 when $2 reaches W.
REQ-036 ori $3 (tnew=1), next beq rs=$3 (tuse=0) -> stall 1 cycle, then fwd_rs_sel=2, no stall.
REQ-037 addu $5 (tnew=0) then addu $5 (tnew=1), then read $5 tuse=0 -> youngest entry governs: stall 1 cycle, then fwd_rs_sel=2; write to $0 never stalls.
REQ-038 mult (MUL_LAT=5) then mflo -> md_busy 5 cycles, mflo stalled 5 cycles; div then mult -> mult stalled 10 cycles.
REQ-039 Macro undefined, mult then mflo -> stall=0, md_busy=0 throughout.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the decode-stage request and the hazard-unit response into one
// interface.
//   master : drives the decode-stage fields and receives the hazard response
//   slave  : hazard unit; consumes the decode fields and drives the response
// Decode fields : d_valid, d_waddr, d_tnew, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
//                 d_md_start, d_md_div, d_md_use
// Response      : stall, fwd_rs_sel, fwd_rt_sel, md_busy
// SW must equal clog2(STAGES+1) of the attached hazard_scoreboard.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int SW = 2
);
   logic          d_valid;
   logic [4:0]    d_waddr;
   logic [1:0]    d_tnew;
   logic [4:0]    d_rs;
   logic [4:0]    d_rt;
   logic [1:0]    d_tuse_rs;
   logic [1:0]    d_tuse_rt;
   logic          d_md_start;
   logic          d_md_div;
   logic          d_md_use;

   logic          stall;
   logic [SW-1:0] fwd_rs_sel;
   logic [SW-1:0] fwd_rt_sel;
   logic          md_busy;

   modport master (
      output d_valid, d_waddr, d_tnew, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
             d_md_start, d_md_div, d_md_use,
      input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
   );

   modport slave (
      input  d_valid, d_waddr, d_tnew, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
             d_md_start, d_md_div, d_md_use,
      output stall, fwd_rs_sel, fwd_rt_sel, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Tnew/Tuse hazard unit for an in-order pipeline. It tracks the destination
// registers of the STAGES instructions after decode (entry 0 = E). It tells
// decode when to stall and from which stage each source operand should be
// forwarded.
//
// Ports
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high; clears the scoreboard and the md counter
//   bus    : hazard_scoreboard_if.slave (decode request in, stall/forward out)
//
// Parameters
//   STAGES  : number of tracked post-decode stages
//   MUL_LAT : multiply busy cycles
//   DIV_LAT : divide busy cycles
//
// Configuration
//   HAZARD_SCOREBOARD_MD_EN : when defined, the multiply/divide busy counter
//   and its stall term are built. When undefined, md_busy is tied low and the
//   d_md_* inputs are ignored.
//
// stall and the forward selects are combinational from the scoreboard state
// and the current decode inputs. Decode sees them in the same cycle.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int STAGES  = 3,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic               clk,
   input  logic               reset,
   hazard_scoreboard_if.slave bus
);
   localparam int SW     = $clog2(STAGES + 1);
   localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW     = $clog2(MD_MAX + 1);

   // scoreboard entries, index 0 is the youngest (E)
   logic [STAGES-1:0] valid_r;
   logic [4:0]        waddr_r [STAGES];
   logic [1:0]        tnew_r  [STAGES];

   logic          rs_hit_s;
   logic          rt_hit_s;
   logic [1:0]    rs_tnew_s;
   logic [1:0]    rt_tnew_s;
   logic [SW-1:0] rs_idx_s;
   logic [SW-1:0] rt_idx_s;
   logic          rs_stall_s;
   logic          rt_stall_s;
   logic          md_stall_s;
   logic          md_busy_s;
   logic          stall_s;
   logic [SW-1:0] rs_sel_s;
   logic [SW-1:0] rt_sel_s;

   // Youngest-match search. The scan runs from oldest to youngest, so the
   // lowest-index match overwrites any older one.
   always_comb begin
      rs_hit_s  = 1'b0;
      rt_hit_s  = 1'b0;
      rs_tnew_s = 2'd0;
      rt_tnew_s = 2'd0;
      rs_idx_s  = {SW{1'b0}};
      rt_idx_s  = {SW{1'b0}};
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (valid_r[k] && (bus.d_rs != 5'd0) && (waddr_r[k] == bus.d_rs)) begin
            rs_hit_s  = 1'b1;
            rs_tnew_s = tnew_r[k];
            rs_idx_s  = SW'(k + 1);
         end else begin
            rs_hit_s  = rs_hit_s;
         end
         if (valid_r[k] && (bus.d_rt != 5'd0) && (waddr_r[k] == bus.d_rt)) begin
            rt_hit_s  = 1'b1;
            rt_tnew_s = tnew_r[k];
            rt_idx_s  = SW'(k + 1);
         end else begin
            rt_hit_s  = rt_hit_s;
         end
      end
   end

   // Per-source stall and forward select. A tuse of 3 means "not read".
   always_comb begin
      rs_stall_s = rs_hit_s && (bus.d_tuse_rs != 2'd3) && (rs_tnew_s > bus.d_tuse_rs);
      rt_stall_s = rt_hit_s && (bus.d_tuse_rt != 2'd3) && (rt_tnew_s > bus.d_tuse_rt);
      stall_s    = bus.d_valid && (rs_stall_s || rt_stall_s || md_stall_s);
      if (bus.d_valid && rs_hit_s && (rs_tnew_s == 2'd0)) begin
         rs_sel_s = rs_idx_s;
      end else begin
         rs_sel_s = {SW{1'b0}};
      end
      if (bus.d_valid && rt_hit_s && (rt_tnew_s == 2'd0)) begin
         rt_sel_s = rt_idx_s;
      end else begin
         rt_sel_s = {SW{1'b0}};
      end
   end

   // Advance the scoreboard. A stalled decode or an idle decode leaves a
   // bubble in E. Writes to $0 are never tracked.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_r[k] <= 1'b0;
            waddr_r[k] <= 5'd0;
            tnew_r[k]  <= 2'd0;
         end
      end else begin
         for (int k = 1; k < STAGES; k++) begin
            valid_r[k] <= valid_r[k-1];
            waddr_r[k] <= waddr_r[k-1];
            tnew_r[k]  <= (tnew_r[k-1] == 2'd0) ? 2'd0 : (tnew_r[k-1] - 2'd1);
         end
         if (!stall_s && bus.d_valid && (bus.d_waddr != 5'd0)) begin
            valid_r[0] <= 1'b1;
            waddr_r[0] <= bus.d_waddr;
            tnew_r[0]  <= bus.d_tnew;
         end else begin
            valid_r[0] <= 1'b0;
            waddr_r[0] <= 5'd0;
            tnew_r[0]  <= 2'd0;
         end
      end
   end

`ifdef HAZARD_SCOREBOARD_MD_EN
   logic [CW-1:0] md_cnt_r;

   // md busy countdown. It loads only on an accepted issue, which needs the
   // counter at 0 because md_stall_s blocks an issue while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_r <= {CW{1'b0}};
      end else if (bus.d_valid && bus.d_md_start && !stall_s) begin
         md_cnt_r <= bus.d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end else if (md_cnt_r != {CW{1'b0}}) begin
         md_cnt_r <= md_cnt_r - CW'(1);
      end else begin
         md_cnt_r <= md_cnt_r;
      end
   end

   assign md_busy_s  = (md_cnt_r != {CW{1'b0}});
   assign md_stall_s = (bus.d_md_use || bus.d_md_start) && md_busy_s;
`else
   logic          unused_md_s;
   logic [CW-1:0] unused_lat_s;

   assign md_busy_s    = 1'b0;
   assign md_stall_s   = 1'b0;
   assign unused_md_s  = ^{bus.d_md_start, bus.d_md_div, bus.d_md_use};
   assign unused_lat_s = CW'(MUL_LAT) ^ CW'(DIV_LAT);
`endif

   assign bus.stall      = stall_s;
   assign bus.fwd_rs_sel = rs_sel_s;
   assign bus.fwd_rt_sel = rt_sel_s;
   assign bus.md_busy    = md_busy_s;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard with the default parameters
// (STAGES=3, MUL_LAT=5, DIV_LAT=10). Each step drives one decode cycle and
// queues the outputs that decode should see in that cycle. The queued values
// are then checked on the falling edge. The md checks follow
// HAZARD_SCOREBOARD_MD_EN.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      string      tag;
      logic       stall;
      logic [1:0] rs;
      logic [1:0] rt;
      logic       busy;
   } exp_t;

   exp_t expq[$];

   hazard_scoreboard_if #(.SW(2)) bus ();

   hazard_scoreboard dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      bus.d_valid    = 1'b0;
      bus.d_waddr    = 5'd0;
      bus.d_tnew     = 2'd0;
      bus.d_rs       = 5'd0;
      bus.d_rt       = 5'd0;
      bus.d_tuse_rs  = 2'd3;
      bus.d_tuse_rt  = 2'd3;
      bus.d_md_start = 1'b0;
      bus.d_md_div   = 1'b0;
      bus.d_md_use   = 1'b0;
   endtask

   task automatic dec(input logic [4:0] waddr, input logic [1:0] tnew,
                      input logic [4:0] rs, input logic [1:0] tuse_rs,
                      input logic [4:0] rt, input logic [1:0] tuse_rt);
      bus.d_valid    = 1'b1;
      bus.d_waddr    = waddr;
      bus.d_tnew     = tnew;
      bus.d_rs       = rs;
      bus.d_tuse_rs  = tuse_rs;
      bus.d_rt       = rt;
      bus.d_tuse_rt  = tuse_rt;
      bus.d_md_start = 1'b0;
      bus.d_md_div   = 1'b0;
      bus.d_md_use   = 1'b0;
   endtask

   task automatic md(input logic start, input logic div, input logic mduse);
      bus.d_md_start = start;
      bus.d_md_div   = div;
      bus.d_md_use   = mduse;
   endtask

   // queue the expectation for the current decode cycle, compare mid-cycle, advance
   task automatic cyc(input string tag, input logic s, input logic [1:0] rs,
                      input logic [1:0] rt, input logic b);
      exp_t e;
      e.tag = tag; e.stall = s; e.rs = rs; e.rt = rt; e.busy = b;
      expq.push_back(e);
      @(negedge clk);
      e = expq.pop_front();
      checks++;
      assert (bus.stall === e.stall) else begin
         failures++;
         $error("FAIL %s stall got=%0b exp=%0b", e.tag, bus.stall, e.stall);
      end
      checks++;
      assert (bus.fwd_rs_sel === e.rs) else begin
         failures++;
         $error("FAIL %s fwd_rs_sel got=%0d exp=%0d", e.tag, bus.fwd_rs_sel, e.rs);
      end
      checks++;
      assert (bus.fwd_rt_sel === e.rt) else begin
         failures++;
         $error("FAIL %s fwd_rt_sel got=%0d exp=%0d", e.tag, bus.fwd_rt_sel, e.rt);
      end
      checks++;
      assert (bus.md_busy === e.busy) else begin
         failures++;
         $error("FAIL %s md_busy got=%0b exp=%0b", e.tag, bus.md_busy, e.busy);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // after reset: idle, then an mflo with nothing in flight
      cyc("rst_idle", 1'b0, 2'd0, 2'd0, 1'b0);
      dec(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3); md(1'b0, 1'b0, 1'b1);
      cyc("rst_mduse", 1'b0, 2'd0, 2'd0, 1'b0);

      // lw $2 (tnew 2) then add $4 <- $2 (tuse 1): one stall cycle
      dec(5'd2, 2'd2, 5'd1, 2'd1, 5'd0, 2'd3);
      cyc("lw2_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      dec(5'd4, 2'd1, 5'd2, 2'd1, 5'd0, 2'd3);
      cyc("add_stall", 1'b1, 2'd0, 2'd0, 1'b0);
      cyc("add_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      // $2 now in W with tnew 0
      dec(5'd6, 2'd1, 5'd2, 2'd1, 5'd2, 2'd1);
      cyc("lw2_fwd_w", 1'b0, 2'd3, 2'd3, 1'b0);
      // d_valid low hides matches and stalls
      dec(5'd0, 2'd0, 5'd4, 2'd0, 5'd6, 2'd0); bus.d_valid = 1'b0;
      cyc("nvalid", 1'b0, 2'd0, 2'd0, 1'b0);
      // $6 in M, $4 in W, writes to $0 issued
      dec(5'd0, 2'd2, 5'd6, 2'd0, 5'd4, 2'd0);
      cyc("fwd_m_w", 1'b0, 2'd2, 2'd3, 1'b0);
      dec(5'd0, 2'd0, 5'd0, 2'd0, 5'd6, 2'd3);
      cyc("src0_tuse3", 1'b0, 2'd0, 2'd3, 1'b0);

      // ori $3 (tnew 1) then beq rs=$3 (tuse 0)
      dec(5'd3, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
      cyc("ori_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      dec(5'd0, 2'd0, 5'd3, 2'd0, 5'd0, 2'd3);
      cyc("beq_stall", 1'b1, 2'd0, 2'd0, 1'b0);
      cyc("beq_fwd_m", 1'b0, 2'd2, 2'd0, 1'b0);

      // two writers of $5: the youngest (tnew 1) decides
      dec(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      cyc("addu5_a", 1'b0, 2'd0, 2'd0, 1'b0);
      dec(5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
      cyc("addu5_b", 1'b0, 2'd0, 2'd0, 1'b0);
      dec(5'd0, 2'd0, 5'd5, 2'd0, 5'd0, 2'd3);
      cyc("young_stall", 1'b1, 2'd0, 2'd0, 1'b0);
      cyc("young_fwd", 1'b0, 2'd2, 2'd0, 1'b0);

      // rt path: lw $8 then read rt=$8 at tuse 0 -> two stall cycles
      dec(5'd8, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      cyc("lw8_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      dec(5'd0, 2'd0, 5'd0, 2'd3, 5'd8, 2'd0);
      cyc("rt_stall1", 1'b1, 2'd0, 2'd0, 1'b0);
      cyc("rt_stall2", 1'b1, 2'd0, 2'd0, 1'b0);
      cyc("rt_fwd_w", 1'b0, 2'd0, 2'd3, 1'b0);

      // tuse 3 never stalls
      dec(5'd9, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      cyc("lw9_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      dec(5'd0, 2'd0, 5'd9, 2'd3, 5'd0, 2'd3);
      cyc("tuse3", 1'b0, 2'd0, 2'd0, 1'b0);

`ifdef HAZARD_SCOREBOARD_MD_EN
      // mult then mflo: busy 5 cycles, mflo held 5 cycles
      dec(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3); md(1'b1, 1'b0, 1'b0);
      cyc("mult_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      md(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc("mflo_stall", 1'b1, 2'd0, 2'd0, 1'b1);
      cyc("mflo_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      // div then mult: mult held 10 cycles, then busy 5 more
      md(1'b1, 1'b1, 1'b0);
      cyc("div_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      md(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cyc("mult_stall", 1'b1, 2'd0, 2'd0, 1'b1);
      cyc("mult_accept", 1'b0, 2'd0, 2'd0, 1'b0);
      idle();
      for (int i = 0; i < 5; i++) cyc("mult_busy", 1'b0, 2'd0, 2'd0, 1'b1);
      cyc("mult_done", 1'b0, 2'd0, 2'd0, 1'b0);
`else
      // md feature absent: mult then mflo never stalls or shows busy
      dec(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3); md(1'b1, 1'b0, 1'b0);
      cyc("mult_nomd", 1'b0, 2'd0, 2'd0, 1'b0);
      md(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc("mflo_nomd", 1'b0, 2'd0, 2'd0, 1'b0);
`endif

      // reset mid-flight drops lw $10 (and a div when md is built)
      dec(5'd10, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
`ifdef HAZARD_SCOREBOARD_MD_EN
      md(1'b1, 1'b1, 1'b0);
`endif
      cyc("lw10_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      reset = 1'b1;
      idle();
      @(posedge clk);
      #1;
      reset = 1'b0;
      dec(5'd0, 2'd0, 5'd10, 2'd0, 5'd0, 2'd3); md(1'b0, 1'b0, 1'b1);
      cyc("midrst_read", 1'b0, 2'd0, 2'd0, 1'b0);
      idle();
      cyc("midrst_idle", 1'b0, 2'd0, 2'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
